// File: rtl/clk_phase_gen_pkg.sv
// Shared types and helpers for the clock-phase generator: FSM states, the
// per-channel {div, high, phase} record, config validation and default phases.
package clk_phase_gen_pkg;

  // Widest supported config field; narrower CW ports are zero-extended to it.
  localparam int unsigned CW_MAX = 16;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCK   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CW_MAX-1:0] div;
    logic [CW_MAX-1:0] high;
    logic [CW_MAX-1:0] phase;
  } cfg_t;

  function automatic logic cfg_is_valid(input cfg_t c);
    return (c.div >= CW_MAX'(2)) && (c.high != '0) && (c.high < c.div) &&
           (c.phase < c.div);
  endfunction

  function automatic logic [CW_MAX-1:0] default_phase(input int unsigned idx,
                                                      input int unsigned step,
                                                      input int unsigned div);
    return CW_MAX'((idx * step) % div);
  endfunction

endpackage

// File: rtl/clk_phase_chan.sv
// One output channel: active config, free-running period counter and the
// registered level / rise-strobe outputs, reloaded from the shadow on align.
module clk_phase_chan
  import clk_phase_gen_pkg::*;
#(
  parameter int unsigned DEF_DIV   = 4,
  parameter int unsigned DEF_HIGH  = 2,
  parameter int unsigned DEF_PHASE = 0
) (
  input  logic refclk,
  input  logic rst,
  input  logic align_i,
  input  cfg_t shadow_i,
  output logic outclk_o,
  output logic rise_o
);

  cfg_t              act_q;
  logic [CW_MAX-1:0] cnt_q;
  logic [CW_MAX-1:0] cnt_d;
  logic [CW_MAX-1:0] high_sel;
  logic              outclk_q;
  logic              rise_q;

  // Starting at div-phase makes the first wrap to 0 land exactly phase cycles
  // after the align edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cnt_d    = '0;
    high_sel = act_q.high;
    if (align_i) begin
      high_sel = shadow_i.high;
      if (shadow_i.phase != '0) begin
        cnt_d = shadow_i.div - shadow_i.phase;
      end
    end else if (cnt_q != act_q.div - CW_MAX'(1)) begin
      cnt_d = cnt_q + CW_MAX'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      act_q    <= '{div:   CW_MAX'(DEF_DIV),
                    high:  CW_MAX'(DEF_HIGH),
                    phase: CW_MAX'(DEF_PHASE)};
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (align_i) begin
        act_q <= shadow_i;
      end
      cnt_q    <= cnt_d;
      outclk_q <= (cnt_d < high_sel);
      rise_q   <= (cnt_d == '0);
    end
  end

  assign outclk_o = outclk_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/clk_phase_gen.sv
// Runtime-configurable multi-channel clock-phase generator: shadow config with
// valid/ready writes, ALIGN/SETTLE/LOCK sequencing and per-channel dividers.
module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int unsigned NUM_CLK        = 2,
  parameter int unsigned CW             = 8,
  parameter int unsigned DEF_DIV        = 4,
  parameter int unsigned DEF_HIGH       = 2,
  parameter int unsigned DEF_PHASE_STEP = 2,
  parameter int unsigned LOCK_CYCLES    = 16,
  localparam int unsigned CHW = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CHW-1:0]     cfg_chan,
  input  logic [CW-1:0]      cfg_div,
  input  logic [CW-1:0]      cfg_high,
  input  logic [CW-1:0]      cfg_phase,
  input  logic               cfg_commit,
  output logic               cfg_err,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] outclk_rise,
  output logic               locked
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

  state_e         state_q;
  logic [LCW-1:0] settle_q;
  logic           locked_q;
  logic           cfg_ready_q;
  logic           cfg_err_q;
  cfg_t           shadow_q [NUM_CLK];
  cfg_t           wr_cfg;
  logic           accept;
  logic           wr_ok;
  logic           commit;
  logic           align;

  assign wr_cfg.div   = CW_MAX'(cfg_div);
  assign wr_cfg.high  = CW_MAX'(cfg_high);
  assign wr_cfg.phase = CW_MAX'(cfg_phase);

  assign accept = cfg_valid && cfg_ready_q;
  assign wr_ok  = (32'(cfg_chan) < NUM_CLK) && cfg_is_valid(wr_cfg);
  assign commit = accept && wr_ok && cfg_commit;
  assign align  = (state_q == ALIGN);

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow array is deliberately reset: defaults must be live
      // straight out of reset, so it is built from flops rather than a RAM.
      for (int i = 0; i < NUM_CLK; i++) begin
        shadow_q[i] <= '{div:   CW_MAX'(DEF_DIV),
                         high:  CW_MAX'(DEF_HIGH),
                         phase: default_phase(i, DEF_PHASE_STEP, DEF_DIV)};
      end
    end else if (accept && wr_ok) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        if (cfg_chan == CHW'(i)) begin
          shadow_q[i] <= wr_cfg;
        end
      end
    end
  end

  // A commit takes priority over lock completion: the old sequence is dropped
  // and SETTLE restarts from zero after the next ALIGN.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ALIGN;
      settle_q    <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= accept && !wr_ok;
      unique case (state_q)
        ALIGN: begin
          state_q     <= SETTLE;
          settle_q    <= '0;
          locked_q    <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        SETTLE, LOCK: begin
          if (commit) begin
            state_q     <= ALIGN;
            cfg_ready_q <= 1'b0;
          end else if (state_q == SETTLE) begin
            if (settle_q == LCW'(LOCK_CYCLES)) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
            end else begin
              settle_q <= settle_q + LCW'(1);
            end
          end
        end
        default: begin
          state_q     <= ALIGN;
          cfg_ready_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
    clk_phase_chan #(
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH),
      .DEF_PHASE(int'(default_phase(g, DEF_PHASE_STEP, DEF_DIV)))
    ) u_chan (
      .refclk  (refclk),
      .rst     (rst),
      .align_i (align),
      .shadow_i(shadow_q[g]),
      .outclk_o(outclk[g]),
      .rise_o  (outclk_rise[g])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Randomised bench for clk_phase_gen: a timestamp-based reference model feeds a
// scoreboard queue that a negedge monitor compares against the DUT every cycle.
module tb_clk_phase_gen;

  localparam int unsigned NUM_CLK        = 3;
  localparam int unsigned CW             = 8;
  localparam int unsigned DEF_DIV        = 4;
  localparam int unsigned DEF_HIGH       = 2;
  localparam int unsigned DEF_PHASE_STEP = 2;
  localparam int unsigned LOCK_CYCLES    = 16;
  localparam int unsigned CHW            = 2;

  logic               refclk     = 1'b0;
  logic               rst        = 1'b0;
  logic               cfg_valid  = 1'b0;
  logic               cfg_commit = 1'b0;
  logic [CHW-1:0]     cfg_chan   = '0;
  logic [CW-1:0]      cfg_div    = '0;
  logic [CW-1:0]      cfg_high   = '0;
  logic [CW-1:0]      cfg_phase  = '0;
  logic               cfg_ready;
  logic               cfg_err;
  logic               locked;
  logic [NUM_CLK-1:0] outclk;
  logic [NUM_CLK-1:0] outclk_rise;

  clk_phase_gen #(
    .NUM_CLK       (NUM_CLK),
    .CW            (CW),
    .DEF_DIV       (DEF_DIV),
    .DEF_HIGH      (DEF_HIGH),
    .DEF_PHASE_STEP(DEF_PHASE_STEP),
    .LOCK_CYCLES   (LOCK_CYCLES)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .outclk     (outclk),
    .outclk_rise(outclk_rise),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_mon   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NUM_CLK-1:0] clk;
    logic [NUM_CLK-1:0] rise;
    logic               locked;
    logic               ready;
    logic               err;
  } exp_t;

  exp_t sb_q[$];

  int e;            // edges since reset release
  int a;            // edge that executed the latest ALIGN
  bit align_next;
  bit m_locked, m_ready, m_err;
  int sh_div[NUM_CLK], sh_high[NUM_CLK], sh_ph[NUM_CLK];
  int act_div[NUM_CLK], act_high[NUM_CLK], act_ph[NUM_CLK];

  task automatic model_reset();
    e = 0;
    a = 0;
    align_next = 1'b1;
    m_locked = 1'b0;
    m_ready  = 1'b0;
    m_err    = 1'b0;
    for (int i = 0; i < NUM_CLK; i++) begin
      sh_div[i]  = DEF_DIV;
      sh_high[i] = DEF_HIGH;
      sh_ph[i]   = (i * DEF_PHASE_STEP) % DEF_DIV;
      act_div[i] = sh_div[i]; act_high[i] = sh_high[i]; act_ph[i] = sh_ph[i];
    end
  endtask

  function automatic bit write_ok();
    int ch, dv, hi, ph;
    ch = int'(cfg_chan); dv = int'(cfg_div); hi = int'(cfg_high); ph = int'(cfg_phase);
    return (ch < NUM_CLK) && (dv >= 2) && (hi >= 1) && (hi < dv) && (ph < dv);
  endfunction

  task automatic model_step();
    e++;
    m_err = 1'b0;
    if (align_next) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        act_div[i] = sh_div[i]; act_high[i] = sh_high[i]; act_ph[i] = sh_ph[i];
      end
      a = e;
      align_next = 1'b0;
      m_locked = 1'b0;
      m_ready  = 1'b1;
    end else begin
      if (cfg_valid && m_ready) begin
        if (write_ok()) begin
          sh_div[cfg_chan]  = int'(cfg_div);
          sh_high[cfg_chan] = int'(cfg_high);
          sh_ph[cfg_chan]   = int'(cfg_phase);
          if (cfg_commit) begin
            align_next = 1'b1;
            m_ready    = 1'b0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (!align_next && e == a + LOCK_CYCLES + 1) m_locked = 1'b1;
    end
  endtask

  // Position within the period measured from the align edge, shifted by phase.
  function automatic exp_t model_outputs();
    exp_t x;
    int d, m;
    x = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      d = e - a - act_ph[i];
      m = ((d % act_div[i]) + act_div[i]) % act_div[i];
      x.clk[i]  = (m < act_high[i]);
      x.rise[i] = (m == 0);
    end
    x.locked = m_locked;
    x.ready  = m_ready;
    x.err    = m_err;
    return x;
  endfunction

  always @(posedge refclk) begin : model_p
    exp_t x;
    if (!rst) begin
      model_reset();
      x = '0;
    end else begin
      model_step();
      x = model_outputs();
    end
    sb_q.push_back(x);
  end

  always @(negedge refclk) begin : monitor_p
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_mon++;
      check("outclk",      outclk,      x.clk);
      check("outclk_rise", outclk_rise, x.rise);
      check("locked",      locked,      x.locked);
      check("cfg_ready",   cfg_ready,   x.ready);
      check("cfg_err",     cfg_err,     x.err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi, input int ph,
                           input bit commit);
    int guard;
    guard = 0;
    while (!cfg_ready && guard < 50) begin
      @(negedge refclk);
      guard++;
    end
    check("wr_ready_wait", guard < 50, 1);
    cfg_valid  = 1'b1;
    cfg_chan   = CHW'(ch);
    cfg_div    = CW'(dv);
    cfg_high   = CW'(hi);
    cfg_phase  = CW'(ph);
    cfg_commit = commit;
    @(negedge refclk);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (!locked && n < 200) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic random_write();
    int ch, dv, hi, ph;
    if ($urandom_range(0, 9) < 7) begin
      ch = $urandom_range(0, NUM_CLK - 1);
      dv = $urandom_range(2, 12);
      hi = $urandom_range(1, dv - 1);
      ph = $urandom_range(0, dv - 1);
    end else begin
      ch = $urandom_range(0, 3);
      dv = $urandom_range(0, 10);
      hi = $urandom_range(0, 10);
      ph = $urandom_range(0, 10);
    end
    cfg_write(ch, dv, hi, ph, $urandom_range(0, 5) == 0);
  endtask

  initial begin : watchdog_p
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim_p
    int cnt;
    // Reset defaults and first lock timing.
    repeat (3) @(negedge refclk);
    #2 rst = 1'b1;
    wait_locked(cnt);
    check("lock_after_reset", cnt, LOCK_CYCLES + 2);
    idle(8);

    // Commit in LOCK retimes ch1 only.
    cfg_write(1, 6, 1, 3, 1'b1);
    idle(40);

    // Two writes applied on one ALIGN: ch1 half a period behind ch0.
    cfg_write(0, 8, 4, 0, 1'b0);
    idle(3);
    cfg_write(1, 8, 4, 4, 1'b1);
    idle(40);

    // Invalid writes in LOCK: one-cycle error, lock held, commit ignored.
    cfg_write(0, 5, 5, 0, 1'b1);
    check("err_high_eq_div", cfg_err, 1);
    check("lock_kept_high",  locked,  1);
    idle(1);
    check("err_cleared", cfg_err, 0);
    cfg_write(0, 6, 2, 6, 1'b1);
    check("err_phase_eq_div", cfg_err, 1);
    idle(2);
    cfg_write(0, 1, 0, 0, 1'b1);
    check("err_div_one", cfg_err, 1);
    idle(2);
    cfg_write(3, 4, 2, 0, 1'b1);
    check("err_bad_chan", cfg_err, 1);
    check("lock_kept_chan", locked, 1);
    idle(4);

    // Commit at SETTLE cycle 10 restarts the lock sequence.
    cfg_write(0, 4, 2, 0, 1'b1);
    idle(11);
    cfg_write(1, 4, 2, 2, 1'b1);
    wait_locked(cnt);
    check("lock_after_resettle", cnt, LOCK_CYCLES + 2);
    idle(5);

    // Randomised traffic.
    for (int k = 0; k < 250; k++) begin
      random_write();
      idle($urandom_range(0, 8));
      if (k % 50 == 49) idle(25);
    end

    // Asynchronous reset in the middle of SETTLE.
    cfg_write(2, 5, 3, 1, 1'b1);
    idle(5);
    #2 rst = 1'b0;
    #1;
    check("async_outclk", outclk,      0);
    check("async_rise",   outclk_rise, 0);
    check("async_locked", locked,      0);
    check("async_ready",  cfg_ready,   0);
    repeat (3) @(negedge refclk);
    #2 rst = 1'b1;
    wait_locked(cnt);
    check("lock_after_rerst", cnt, LOCK_CYCLES + 2);
    idle(20);

    check("monitor_active", n_mon > 1000, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised multi-output clock-phase generator in the `refclk` domain. It produces `NUM_CLK` divided, duty-programmable, phase-offset clock levels with one-cycle rise strobes and a `locked` indication. Divide, duty and phase are reconfigurable at run time through a valid/ready port, and all channels resynchronise on commit. It is the fabric-side, runtime-configurable successor to the fixed two-output PLL wrapper and drives datapath phase enables in the processor.

## Interface
- `NUM_CLK`, 2: number of output channels, 1..8.
- `CW`, 8: counter/config field width; max divide is 2^CW-1.
- `DEF_DIV`, 4: reset divide ratio, all channels, ≥2.
- `DEF_HIGH`, 2: reset high-cycle count, 1..DEF_DIV-1.
- `DEF_PHASE_STEP`, 2: reset phase of channel i is (i*DEF_PHASE_STEP) mod DEF_DIV.
- `LOCK_CYCLES`, 16: SETTLE length in refclk cycles, ≥1.

Ports:
- `refclk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted when both are high.
- `cfg_chan` in max(1,$clog2(NUM_CLK)): target channel.
- `cfg_div` in CW: divide ratio.
- `cfg_high` in CW: high cycles per period.
- `cfg_phase` in CW: rising-edge delay after align, in refclk cycles.
- `cfg_commit` in 1: apply all shadow settings and resync after this write.
- `cfg_err` out 1: one-cycle pulse, accepted write rejected.
- `outclk` out NUM_CLK: channel levels.
- `outclk_rise` out NUM_CLK: high in the first high cycle of each period.
- `locked` out 1: outputs stable and aligned.

## Operation
- Each channel keeps shadow and active {div, high, phase}. Reset loads both with the defaults.
- Write validity: cfg_chan < NUM_CLK, div ≥ 2, 1 ≤ high < div, phase < div.
  - Invalid write: shadow and state unchanged, commit ignored, cfg_err = 1 on the next cycle.
  - Valid write: updates shadow[cfg_chan] only.
- FSM states are ALIGN, SETTLE and LOCK. Reset state is ALIGN.
  - ALIGN, 1 cycle: active ← shadow for all channels; cnt_i ← (phase_i == 0) ? 0 : div_i − phase_i; next state SETTLE.
  - SETTLE: a counter runs for LOCK_CYCLES cycles, then the FSM goes to LOCK.
  - LOCK: holds.
  - In SETTLE or LOCK, an accepted valid write with cfg_commit = 1 moves the FSM to ALIGN on the next edge.
- Counters run in SETTLE and LOCK: cnt_i wraps from div_i−1 to 0.
  - outclk[i] = (cnt_i < high_i).
  - outclk_rise[i] = (cnt_i == 0).
  - Both are registered alongside cnt, so they add no latency relative to cnt.
- Channel outputs free-run during SETTLE. Consumers gate on `locked`.

## Timing
- Reset asserted: state ALIGN, all outputs 0 (outclk, outclk_rise, locked, cfg_err, cfg_ready), counters 0, shadows and actives at defaults.
- cfg_ready = 0 in ALIGN and 1 in SETTLE/LOCK.
- After reset release:
  - First edge executes ALIGN.
  - locked rises on edge LOCK_CYCLES+2, i.e. after ALIGN plus LOCK_CYCLES SETTLE cycles.
  - A phase-0 channel is high in the first SETTLE cycle.
- Commit accepted on edge k: ALIGN at k+1, locked falls at k+1, locked re-rises at k+2+LOCK_CYCLES.
- Non-commit writes: no effect on outputs or locked.
- Commit during SETTLE restarts the full sequence. The SETTLE count is not resumed.
- Rising edge of channel i occurs exactly phase_i cycles after the first SETTLE cycle, then every div_i cycles.
- Asynchronous reset mid-operation: immediate return to reset values, with no partial config retained.

## Structure
- Shared package `clk_phase_gen_pkg`:
  - state enum {ALIGN, SETTLE, LOCK};
  - cfg record struct {div, high, phase};
  - validity check function;
  - default-phase function.
- Sub-module `clk_phase_chan`: one channel's counter, active regs, load on align, and outclk/outclk_rise registers. It is instantiated NUM_CLK times by a generate loop.
- Top level holds the shadows, the config handshake/error logic, the FSM and the lock counter.

## Test plan
- Reset defaults (NUM_CLK=2, DIV 4, HIGH 2, STEP 2):
  - ch0 SETTLE pattern 1,1,0,0 repeating; ch1 0,0,1,1;
  - rise strobes on ch0 cycle 0 and ch1 cycle 2;
  - locked = 1 at edge 18.
- Write ch1 {6,1,3} with commit=1 in LOCK:
  - locked drops next cycle, cfg_ready = 0 for one cycle;
  - ch1 first rise 3 cycles into SETTLE, then period 6 and high 1;
  - ch0 unchanged at div 4.
- Write ch0 {8,4,0} commit=0, then ch1 {8,4,4} commit=1:
  - both channels apply on the same ALIGN;
  - ch1 is exactly 180° (4 cycles) behind ch0.
- Invalid writes each give cfg_err = 1 for one cycle, no state change, and locked stays 1:
  - high = div (5,5,0);
  - phase = div;
  - div = 1;
  - cfg_chan = 2.
- Commit at SETTLE cycle 10: locked does not assert at the old time, and asserts 16 cycles after the new ALIGN.
- Assert rst mid-SETTLE between edges:
  - outputs go to 0 asynchronously;
  - after release, default patterns and lock timing match scenario 1.
